// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit bundle: decode/EX observations in, pipeline write/flush controls and perf counters out.
// master = pipeline datapath side, slave = pipeline_hazard_unit.
interface pipeline_hazard_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       i_ID_rs;
  logic [4:0]       i_ID_rt;
  logic             i_ID_uses_rs;
  logic             i_ID_uses_rt;
  logic             i_ID_Jump;
  logic             i_EX_MemRead;
  logic [4:0]       i_EX_rt;
  logic             i_EX_BranchTaken;
  logic             o_PC_Write;
  logic             o_IF_ID_Write;
  logic             o_IF_ID_flush;
  logic             o_ID_EX_flush;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_ID_rs, i_ID_rt, i_ID_uses_rs, i_ID_uses_rt, i_ID_Jump,
           i_EX_MemRead, i_EX_rt, i_EX_BranchTaken,
    input  o_PC_Write, o_IF_ID_Write, o_IF_ID_flush, o_ID_EX_flush,
           o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_ID_rs, i_ID_rt, i_ID_uses_rs, i_ID_uses_rt, i_ID_Jump,
           i_EX_MemRead, i_EX_rt, i_EX_BranchTaken,
    output o_PC_Write, o_IF_ID_Write, o_IF_ID_flush, o_ID_EX_flush,
           o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall / branch & jump flush control for the IF/ID and ID/EX registers.
// Optional saturating stall/flush event counters when PERF_COUNTERS_EN is defined.
module pipeline_hazard_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_unit_if.slave  hz
);

  localparam int unsigned   CW         = 4;
  localparam bit            MULTI      = (LOAD_STALL_CYCLES > 1);
  localparam logic [CW-1:0] STALL_INIT = MULTI ? CW'(LOAD_STALL_CYCLES - 2) : '0;

  typedef enum logic [0:0] {ST_RUN, ST_STALL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_c;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic          stall_ev, flush_ev;

  // Load in EX whose destination is a live source of the ID instruction; $zero never hazards.
  assign hit_c = hz.i_EX_MemRead & (hz.i_EX_rt != 5'd0) &
                 ((hz.i_ID_uses_rs & (hz.i_ID_rs == hz.i_EX_rt)) |
                  (hz.i_ID_uses_rt & (hz.i_ID_rt == hz.i_EX_rt)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs act in the same cycle as their cause; reset low forces the free-running pattern.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    if (reset) begin
      if (hz.i_EX_BranchTaken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_ev    = 1'b1;
        state_d     = ST_RUN;
        cnt_d       = '0;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            if (hit_c) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
              stall_ev    = 1'b1;
              if (MULTI) begin
                state_d = ST_STALL;
                cnt_d   = STALL_INIT;
              end
            end else if (hz.i_ID_Jump) begin
              if_id_flush = 1'b1;
              flush_ev    = 1'b1;
            end
          end
          ST_STALL: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_ev    = 1'b1;
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - CW'(1);
          end
          default: state_d = ST_RUN;
        endcase
      end
    end
  end

  assign hz.o_PC_Write    = pc_write;
  assign hz.o_IF_ID_Write = if_id_write;
  assign hz.o_IF_ID_flush = if_id_flush;
  assign hz.o_ID_EX_flush = id_ex_flush;

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ev && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.o_stall_cnt = stall_cnt_q;
  assign hz.o_flush_cnt = flush_cnt_q;
`else
  logic unused_ev;
  assign unused_ev      = stall_ev | flush_ev;
  assign hz.o_stall_cnt = '0;
  assign hz.o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: two instances (1-cycle and 3-cycle load stall, narrow counter)
// driven by the same stimulus and compared against a bubble-budget reference model.
module tb_pipeline_hazard_unit;

  localparam int unsigned CNT_W_A = 32;
  localparam int unsigned CNT_W_B = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.CNT_W(CNT_W_A)) ifa ();
  pipeline_hazard_unit_if #(.CNT_W(CNT_W_B)) ifb ();

  assign ifb.i_ID_rs          = ifa.i_ID_rs;
  assign ifb.i_ID_rt          = ifa.i_ID_rt;
  assign ifb.i_ID_uses_rs     = ifa.i_ID_uses_rs;
  assign ifb.i_ID_uses_rt     = ifa.i_ID_uses_rt;
  assign ifb.i_ID_Jump        = ifa.i_ID_Jump;
  assign ifb.i_EX_MemRead     = ifa.i_EX_MemRead;
  assign ifb.i_EX_rt          = ifa.i_EX_rt;
  assign ifb.i_EX_BranchTaken = ifa.i_EX_BranchTaken;

  pipeline_hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(CNT_W_A)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .hz    (ifa.slave)
  );

  pipeline_hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(CNT_W_B)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .hz    (ifb.slave)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  int     rem  [2] = '{0, 0};
  longint scnt [2] = '{0, 0};
  longint fcnt [2] = '{0, 0};
  int     lsc  [2] = '{1, 3};
  longint cmax [2] = '{64'hFFFF_FFFF, 64'd7};

  task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  function automatic bit model_hit();
    if (!ifa.i_EX_MemRead || ifa.i_EX_rt == 5'd0) return 1'b0;
    return (ifa.i_ID_uses_rs && ifa.i_ID_rs == ifa.i_EX_rt) ||
           (ifa.i_ID_uses_rt && ifa.i_ID_rt == ifa.i_EX_rt);
  endfunction

  // One clock: predict, check at negedge, advance model at posedge.
  task automatic cycle();
    logic [3:0]  ex [2];
    bit          sev [2];
    bit          fev [2];
    bit          h, br, jp, rs;
    logic [31:0] obs_s, obs_f, exp_s, exp_f;
    logic [3:0]  obs;
    h  = model_hit();
    br = ifa.i_EX_BranchTaken;
    jp = ifa.i_ID_Jump;
    rs = reset;
    for (int i = 0; i < 2; i++) begin
      sev[i] = 1'b0;
      fev[i] = 1'b0;
      if (!rs) begin
        rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
        ex[i] = 4'b1100;
      end else if (br) begin
        ex[i] = 4'b1111; fev[i] = 1'b1;
      end else if (rem[i] > 0 || h) begin
        ex[i] = 4'b0001; sev[i] = 1'b1;
      end else if (jp) begin
        ex[i] = 4'b1110; fev[i] = 1'b1;
      end else begin
        ex[i] = 4'b1100;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        obs   = {ifa.o_PC_Write, ifa.o_IF_ID_Write, ifa.o_IF_ID_flush, ifa.o_ID_EX_flush};
        obs_s = 32'(ifa.o_stall_cnt);
        obs_f = 32'(ifa.o_flush_cnt);
      end else begin
        obs   = {ifb.o_PC_Write, ifb.o_IF_ID_Write, ifb.o_IF_ID_flush, ifb.o_ID_EX_flush};
        obs_s = 32'(ifb.o_stall_cnt);
        obs_f = 32'(ifb.o_flush_cnt);
      end
`ifdef PERF_COUNTERS_EN
      exp_s = 32'(scnt[i]);
      exp_f = 32'(fcnt[i]);
`else
      exp_s = 32'd0;
      exp_f = 32'd0;
`endif
      check("pc_write",    i, 32'(obs[3]), 32'(ex[i][3]));
      check("if_id_write", i, 32'(obs[2]), 32'(ex[i][2]));
      check("if_id_flush", i, 32'(obs[1]), 32'(ex[i][1]));
      check("id_ex_flush", i, 32'(obs[0]), 32'(ex[i][0]));
      check("stall_cnt",   i, obs_s, exp_s);
      check("flush_cnt",   i, obs_f, exp_f);
    end
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < 2; i++) begin
        if (br)             rem[i] = 0;
        else if (rem[i] > 0) rem[i] = rem[i] - 1;
        else if (h)         rem[i] = lsc[i] - 1;
        if (sev[i] && scnt[i] < cmax[i]) scnt[i]++;
        if (fev[i] && fcnt[i] < cmax[i]) fcnt[i]++;
      end
    end
    #1;
  endtask

  task automatic set_in(input bit mr, input logic [4:0] ert, input logic [4:0] rsf, input bit urs,
                        input logic [4:0] rtf, input bit urt, input bit jmp, input bit brt);
    ifa.i_EX_MemRead     = mr;
    ifa.i_EX_rt          = ert;
    ifa.i_ID_rs          = rsf;
    ifa.i_ID_uses_rs     = urs;
    ifa.i_ID_rt          = rtf;
    ifa.i_ID_uses_rt     = urt;
    ifa.i_ID_Jump        = jmp;
    ifa.i_EX_BranchTaken = brt;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1, 5'd8, 5'd8, 1, 5'd0, 0, 1, 0);
    @(posedge clk); #1;
    cycle();                                     // reset forces normal outputs despite hazard inputs
    cycle();
    reset = 1'b1;
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    cycle();                                     // idle
    set_in(1, 5'd8, 5'd8, 1, 5'd9, 1, 0, 0);
    cycle();                                     // lw $t0 then add using $t0
    set_in(0, 5'd0, 5'd8, 1, 5'd9, 1, 0, 0);
    repeat (3) cycle();                          // bubble in EX; dut1 still stalling
    set_in(1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
    cycle();                                     // $zero destination
    set_in(1, 5'd5, 5'd1, 1, 5'd5, 1, 0, 1);
    cycle();                                     // branch beats hazard
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    cycle();
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    cycle();                                     // lone jump
    set_in(1, 5'd8, 5'd8, 1, 5'd0, 0, 0, 0);
    cycle();                                     // start 3-cycle stall
    set_in(0, 5'd0, 5'd8, 1, 5'd0, 0, 0, 0);
    reset = 1'b0;
    cycle();                                     // reset mid-stall
    reset = 1'b1;
    cycle();
    set_in(1, 5'd3, 5'd0, 0, 5'd3, 1, 0, 0);
    cycle();
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1);
    cycle();                                     // branch aborts stall
    cycle();
    for (int n = 0; n < 600; n++) begin
      set_in(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) != 0);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
